// File: rtl/multiplier_8bit_seq_pkg.sv
// Shared ALU definitions: sequencer state encodings and default operand width.
package multiplier_8bit_seq_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CALC = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/multiplier_8bit_seq.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Fixed latency: WIDTH cycles in CALC, one-cycle DONE pulse, then IDLE.
module multiplier_8bit_seq
   import multiplier_8bit_seq_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   A_input,
   input  logic [WIDTH-1:0]   B_input,
   output logic [2*WIDTH-1:0] product,
   output logic               busy,
   output logic               done
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] addend;
   logic [CW-1:0]      cnt;
   logic               last;

   // Multiplicand aligned to the weight of the multiplier bit being consumed
   assign addend  = {{WIDTH{1'b0}}, a_reg} << cnt;
   assign acc_nxt = b_reg[0] ? acc + addend : acc;
   assign last    = (cnt == CW'(WIDTH - 1));

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         a_reg   <= '0;
         b_reg   <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_reg <= A_input;
                  b_reg <= B_input;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= ST_CALC;
               end
            end
            ST_CALC: begin
               acc   <= acc_nxt;
               b_reg <= b_reg >> 1;
               cnt   <= cnt + CW'(1);
               // Final step writes the completed sum straight to the output
               if (last) begin
                  product <= acc_nxt;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiplier_8bit_seq.sv
// Directed bench: WIDTH=8 instance for latency/control cases,
// WIDTH=4 instance swept over every operand pair.
module tb_multiplier_8bit_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic [15:0] p8;
   logic        busy8;
   logic        done8;
   logic        s4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic [7:0]  p4;
   logic        busy4;
   logic        done4;

   int total = 0;
   int bad = 0;

   multiplier_8bit_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(s8),
      .A_input(a8), .B_input(b8),
      .product(p8), .busy(busy8), .done(done8)
   );

   multiplier_8bit_seq #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .start(s4),
      .A_input(a4), .B_input(b4),
      .product(p4), .busy(busy4), .done(done4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // lat counts edges from the one that samples start, inclusive
   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] prev,
                       output int lat, output logic [15:0] p);
      a8 = a;
      b8 = b;
      s8 = 1'b1;
      tick;
      lat = 1;
      s8 = 1'b0;
      while (!done8 && lat < 30) begin
         tick;
         lat++;
         if (lat == 5) chk("calc_hold", p8, prev);
      end
      p = p8;
   endtask

   initial begin
      int lat;
      int k;
      int nd;
      int last;
      bit seen;
      logic [15:0] p;

      #2;
      chk("rst_prod", p8, 16'h0);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      tick;
      rst = 1'b0;

      run8(8'd255, 8'd255, 16'h0, lat, p);
      chk("ff_lat", lat, 9);
      chk("ff_prod", p, 16'hFE01);
      chk("ff_busy_in_done", busy8, 1'b1);
      tick;
      chk("ff_busy_after", busy8, 1'b0);
      chk("ff_done_pulse", done8, 1'b0);

      run8(8'd0, 8'd200, 16'hFE01, lat, p);
      chk("z0_lat", lat, 9);
      chk("z0_prod", p, 16'h0);
      tick;
      run8(8'd13, 8'd0, 16'h0, lat, p);
      chk("z1_lat", lat, 9);
      chk("z1_prod", p, 16'h0);
      tick;

      // start held high, operands scrambled whenever CALC is active
      s8 = 1'b1;
      a8 = 8'd13;
      b8 = 8'd11;
      k = 0;
      nd = 0;
      last = -1;
      while (nd < 3 && k < 60) begin
         tick;
         k++;
         if (done8) begin
            chk("bb_prod", p8, 16'd143);
            if (last >= 0) chk("bb_gap", k - last, 10);
            last = k;
            nd++;
         end
         if (busy8 && !done8) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
         end else begin
            a8 = 8'd13;
            b8 = 8'd11;
         end
      end
      chk("bb_count", nd, 3);
      s8 = 1'b0;
      tick;
      tick;

      // abort after four CALC cycles
      a8 = 8'd100;
      b8 = 8'd3;
      s8 = 1'b1;
      tick;
      s8 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (done8) seen = 1'b1;
      end
      rst = 1'b1;
      #1;
      chk("ab_prod", p8, 16'h0);
      chk("ab_busy", busy8, 1'b0);
      chk("ab_done", done8, 1'b0);
      tick;
      rst = 1'b0;
      run8(8'd7, 8'd9, 16'h0, lat, p);
      chk("ab_nodone", seen, 1'b0);
      chk("ab_new_lat", lat, 9);
      chk("ab_new_prod", p, 16'd63);
      tick;

      run8(8'd12, 8'd12, 16'd63, lat, p);
      chk("ret_prod", p, 16'd144);
      for (int i = 0; i < 20; i++) begin
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         tick;
         if (done8) seen = 1'b1;
      end
      chk("ret_hold", p8, 16'd144);
      chk("ret_idle", busy8, 1'b0);
      chk("ret_nodone", seen, 1'b0);

      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            a4 = 4'(i);
            b4 = 4'(j);
            s4 = 1'b1;
            tick;
            s4 = 1'b0;
            k = 0;
            while (!done4 && k < 12) begin
               tick;
               k++;
            end
            if (!done4) chk("w4_timeout", 0, 1);
            chk("w4_prod", p4, 32'(i * j));
            tick;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
